// File: rtl/scan_chain_master.sv
// EXTEST boundary-scan initiator: shifts one pattern into the chain, pulses Update
// then Capture, and unloads the captured pin values into a parallel response word.
module scan_chain_master #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 SI,
    input  logic                 SO,
    output logic                 Shift,
    output logic                 CaptureEn,
    output logic                 UpdateEn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_UPDATE,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic [CHAIN_LEN-1:0] bitMask;
    logic [CHAIN_LEN-1:0] patShifted;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 si_q, si_d;
    logic                 shift_q, shift_d;
    logic                 capture_q, capture_d;
    logic                 update_q, update_d;

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            si_q      <= 1'b0;
            shift_q   <= 1'b0;
            capture_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            si_q      <= si_d;
            shift_q   <= shift_d;
            capture_q <= capture_d;
            update_q  <= update_d;
        end
    end

    // Outputs are registered from the next state, so each one lines up with the
    // cycle the FSM actually occupies without any combinational path to a pin.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        resp_d     = resp_q;
        bitMask    = {{(CHAIN_LEN-1){1'b0}}, 1'b1} << cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_UPDATE:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_UNLOAD;
            S_UNLOAD: begin
                resp_d = SO ? (resp_q | bitMask) : (resp_q & ~bitMask);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        patShifted = pat_d >> cnt_d;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        shift_d    = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
        si_d       = (state_d == S_SHIFT) && patShifted[0];
        update_d   = (state_d == S_UPDATE);
        capture_d  = (state_d == S_CAPTURE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign SI        = si_q;
    assign Shift     = shift_q;
    assign CaptureEn = capture_q;
    assign UpdateEn  = update_q;

endmodule
